// File: rtl/cfg_spi_loader.sv
// cfg_spi_loader: SPI mode-0 slave that turns 24-bit frames into config register writes and mux readback
// Ports: clk_i, rst_i (async, active-high); spi_sclk_i/spi_cs_n_i/spi_mosi_i serial in,
//   spi_miso_o/spi_miso_oe_o serial out; reg_wr_o/reg_adr_o/reg_dat_o register write port;
//   mux_adr_o/mux_i readback mux; busy_o frame in progress; frame_err_o aborted-frame pulse.
// Define CFG_SPI_LOADER_WRCNT_EN to add wr_cnt_o, an 8-bit wrapping count of issued writes.
module cfg_spi_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int MUX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             spi_sclk_i,
  input  logic             spi_cs_n_i,
  input  logic             spi_mosi_i,
  output logic             spi_miso_o,
  output logic             spi_miso_oe_o,
  output logic             reg_wr_o,
  output logic [1:0]       reg_adr_o,
  output logic [15:0]      reg_dat_o,
  output logic [2:0]       mux_adr_o,
  input  logic [MUX_W-1:0] mux_i,
  output logic             busy_o,
  output logic             frame_err_o
`ifdef CFG_SPI_LOADER_WRCNT_EN
  ,
  output logic [7:0]       wr_cnt_o
`endif
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_d1_q, cs_d1_q, armed_q, loaded_q, w_q;
  logic [1:0] adr_q;
  logic [3:0] cnt_q;
  logic [14:0] sh_q;
  logic [15:0] tx_q;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  assign cs_rise = cs_s & ~cs_d1_q;
  assign cs_fall = ~cs_s & cs_d1_q;
  // armed_q: cs_n must be seen high once after reset, so a select already low at reset is not a frame
  assign busy_o = armed_q & ~cs_s;
  assign spi_miso_oe_o = busy_o;
  assign spi_miso_o = tx_q[15];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sclk_q <= '0;
      cs_q <= '0;
      mosi_q <= '0;
      sclk_d1_q <= 1'b0;
      cs_d1_q <= 1'b0;
      armed_q <= 1'b0;
      loaded_q <= 1'b0;
      w_q <= 1'b0;
      adr_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      tx_q <= '0;
      reg_wr_o <= 1'b0;
      reg_adr_o <= '0;
      reg_dat_o <= '0;
      mux_adr_o <= '0;
      frame_err_o <= 1'b0;
`ifdef CFG_SPI_LOADER_WRCNT_EN
      wr_cnt_o <= '0;
`endif
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk_i};
      cs_q <= {cs_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_d1_q <= sclk_s;
      cs_d1_q <= cs_s;
      armed_q <= armed_q | cs_s;
      reg_wr_o <= 1'b0;
      frame_err_o <= 1'b0;
      if (cs_rise && (state_q == CMD || state_q == DATA)) begin
        state_q <= IDLE;
        frame_err_o <= 1'b1;
        cnt_q <= '0;
        tx_q <= '0;
        loaded_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (cs_fall && armed_q) begin
            state_q <= CMD;
            cnt_q <= '0;
          end
          CMD: if (sclk_rise) begin
            sh_q <= {sh_q[13:0], mosi_s};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              w_q <= sh_q[6];
              adr_q <= sh_q[5:4];
              mux_adr_o <= sh_q[3:1];
              cnt_q <= '0;
              state_q <= DATA;
            end
          end
          DATA: if (sclk_rise) begin
            sh_q <= {sh_q[13:0], mosi_s};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              reg_wr_o <= w_q;
              if (w_q) begin
                reg_adr_o <= adr_q;
                reg_dat_o <= {sh_q, mosi_s};
`ifdef CFG_SPI_LOADER_WRCNT_EN
                wr_cnt_o <= wr_cnt_o + 8'd1;
`endif
              end
              cnt_q <= '0;
              tx_q <= '0;
              loaded_q <= 1'b0;
              state_q <= DONE;
            end
          end else if (sclk_fall) begin
            // first fall in DATA is the 8th of the frame: load the readback word, then shift
            tx_q <= loaded_q ? {tx_q[14:0], 1'b0} : 16'(mux_i);
            loaded_q <= 1'b1;
          end
          default: if (cs_rise) state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cfg_spi_loader.sv
// tb_cfg_spi_loader: directed SPI host with a timing-aware expectation model for cfg_spi_loader
`timescale 1ns/1ps
module tb_cfg_spi_loader;
  localparam int SYNC = 2;
  logic clk = 0, rst = 1, sclk = 0, cs_n = 1, mosi = 0;
  logic miso, oe, wr, busy, ferr;
  logic [1:0] radr;
  logic [15:0] rdat;
  logic [2:0] madr;
  logic [5:0] mux;
  logic [5:0] mux_tab [8] = '{6'h11, 6'h22, 6'h33, 6'h3C, 6'h05, 6'h2B, 6'h17, 6'h29};
`ifdef CFG_SPI_LOADER_WRCNT_EN
  logic [7:0] wcnt;
  logic [7:0] exp_cnt = 0;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0, wr_seen = 0, err_seen = 0;
  logic [1:0] exp_adr = 0;
  logic [15:0] exp_dat = 0;
  logic [2:0] exp_mux = 0;
  int wq_due[$];
  logic [17:0] wq_val[$];
  int mq_due[$];
  logic [2:0] mq_val[$];
  logic prev_wr = 0, prev_err = 0;
  logic [31:0] rx;
  logic [23:0] f;
  int de, dw, w0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mux = mux_tab[madr];

  cfg_spi_loader #(.SYNC_STAGES(SYNC), .MUX_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(oe), .reg_wr_o(wr), .reg_adr_o(radr), .reg_dat_o(rdat),
    .mux_adr_o(madr), .mux_i(mux), .busy_o(busy), .frame_err_o(ferr)
`ifdef CFG_SPI_LOADER_WRCNT_EN
    , .wr_cnt_o(wcnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_wr", wr, 0);
    chk("rst_adr", radr, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_mux", madr, 0);
    chk("rst_miso", miso, 0);
    chk("rst_oe", oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", ferr, 0);
  endtask

  // writes and mux updates must appear SYNC+1 cycles after the raw sclk rise that completes them
  task automatic frame(input logic [7:0] cmd, input logic [15:0] dat, input int np,
                       output logic [31:0] r, output int d_err, output int d_wr);
    logic [23:0] fr;
    int e0, w1;
    fr = {cmd, dat};
    r = 0;
    e0 = err_seen;
    w1 = wr_seen;
    cs_n = 0;
    tick(4);
    for (int i = 0; i < np; i++) begin
      mosi = i < 24 ? fr[23-i] : 1'b0;
      tick(4);
      if (i == 0) chk("busy_in_frame", busy, 1);
      sclk = 1;
      r[31-i] = miso;
      if (i == 7) begin
        mq_due.push_back(cyc + SYNC + 1);
        mq_val.push_back(cmd[4:2]);
      end
      if (i == 23 && cmd[7]) begin
        wq_due.push_back(cyc + SYNC + 1);
        wq_val.push_back({cmd[6:5], dat});
      end
      tick(4);
      sclk = 0;
    end
    tick(4);
    cs_n = 1;
    tick(8);
    chk("busy_after_frame", busy, 0);
    d_err = err_seen - e0;
    d_wr = wr_seen - w1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_adr = 0;
      exp_dat = 0;
      exp_mux = 0;
      wq_due.delete();
      wq_val.delete();
      mq_due.delete();
      mq_val.delete();
      prev_wr = 0;
      prev_err = 0;
`ifdef CFG_SPI_LOADER_WRCNT_EN
      exp_cnt = 0;
`endif
    end else begin
      while (mq_due.size() > 0 && cyc >= mq_due[0]) begin
        exp_mux = mq_val.pop_front();
        void'(mq_due.pop_front());
      end
      if (wr) begin
        wr_seen++;
        chk("wr_width", prev_wr, 0);
        if (wq_due.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_wr: got write adr=%0d dat=0x%0h, expected none", radr, rdat);
        end else begin
          chk("wr_latency", cyc, wq_due.pop_front());
          {exp_adr, exp_dat} = wq_val.pop_front();
`ifdef CFG_SPI_LOADER_WRCNT_EN
          exp_cnt = exp_cnt + 8'd1;
`endif
        end
      end else if (wq_due.size() > 0 && cyc > wq_due[0]) begin
        chk("missed_wr", cyc, wq_due.pop_front());
        void'(wq_val.pop_front());
      end
      if (ferr) begin
        err_seen++;
        chk("err_width", prev_err, 0);
      end
      chk("reg_adr", radr, exp_adr);
      chk("reg_dat", rdat, exp_dat);
      chk("mux_adr", madr, exp_mux);
      chk("oe_eq_busy", oe, busy);
`ifdef CFG_SPI_LOADER_WRCNT_EN
      chk("wr_cnt", wcnt, exp_cnt);
`endif
      prev_wr = wr;
      prev_err = ferr;
    end
  end

  initial begin
    tick(3);
    chk_reset();
    rst = 0;
    tick(6);
    chk("idle_busy", busy, 0);
    frame(8'hA0, 16'h1234, 24, rx, de, dw);
    chk("t1_wr_count", dw, 1);
    chk("t1_err", de, 0);
    chk("t1_adr", radr, 2'd1);
    chk("t1_dat", rdat, 16'h1234);
    chk("t1_miso_cmd", rx[31:24], 0);
    chk("t1_miso_data", rx[23:8], 16'h0011);
    frame(8'h14, 16'h0000, 24, rx, de, dw);
    chk("t2_mux_adr", madr, 3'd5);
    chk("t2_miso_data", rx[23:8], 16'h002B);
    chk("t2_miso_cmd", rx[31:24], 0);
    chk("t2_wr_count", dw, 0);
    chk("t2_err", de, 0);
    frame(8'h80, 16'h5555, 18, rx, de, dw);
    chk("t3_abort_err", de, 1);
    chk("t3_abort_wr", dw, 0);
    chk("t3_abort_dat", rdat, 16'h1234);
    frame(8'hE0, 16'hFFFF, 24, rx, de, dw);
    chk("t3_wr_count", dw, 1);
    chk("t3_err", de, 0);
    chk("t3_adr", radr, 2'd3);
    chk("t3_dat", rdat, 16'hFFFF);
    frame(8'hE0, 16'h00FF, 30, rx, de, dw);
    chk("t4_wr_count", dw, 1);
    chk("t4_err", de, 0);
    chk("t4_adr", radr, 2'd3);
    chk("t4_dat", rdat, 16'h00FF);
    chk("t4_miso_extra", rx[7:2], 0);
    chk("t4_miso_data", rx[23:8], 16'h0011);
    f = {8'hE0, 16'hABCD};
    cs_n = 0;
    tick(4);
    for (int i = 0; i < 12; i++) begin
      mosi = f[23-i];
      tick(4);
      sclk = 1;
      tick(4);
      sclk = 0;
    end
    tick(1);
    rst = 1;
    tick(1);
    chk_reset();
    tick(2);
    rst = 0;
    tick(6);
    chk_reset();
    w0 = wr_seen;
    for (int i = 0; i < 8; i++) begin
      mosi = 1;
      tick(4);
      sclk = 1;
      tick(4);
      sclk = 0;
    end
    tick(4);
    chk_reset();
    chk("t5_no_wr_cs_low", wr_seen - w0, 0);
    cs_n = 1;
    tick(8);
    chk("t5_busy_cs_high", busy, 0);
    frame(8'hA0, 16'h5A5A, 24, rx, de, dw);
    chk("t5_wr_count", dw, 1);
    chk("t5_adr", radr, 2'd1);
    chk("t5_dat", rdat, 16'h5A5A);
`ifdef CFG_SPI_LOADER_WRCNT_EN
    rst = 1;
    tick(2);
    rst = 0;
    tick(6);
    for (int k = 0; k < 257; k++) frame(8'hA0, 16'(k), 24, rx, de, dw);
    chk("t6_wr_cnt_257", wcnt, 8'd1);
    frame(8'h14, 16'h0000, 24, rx, de, dw);
    chk("t6_wr_cnt_read", wcnt, 8'd1);
`endif
    tick(8);
    chk("pending_wr", wq_due.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
